// File: rtl/jk_ff.sv
// Bank of WIDTH independent JK flip-flops with synchronous active-high reset.
// Optional clock enable port CE is built in when JK_FF_CE_EN is defined.
module jk_ff #(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             Clk,
  input  logic             Rst,
`ifdef JK_FF_CE_EN
  input  logic             CE,
`endif
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_b
);

  logic             en;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

`ifdef JK_FF_CE_EN
  assign en = CE;
`else
  assign en = 1'b1;
`endif

  always_comb begin
    q_d = q_q;
    if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        unique case ({J[i], K[i]})
          2'b00:   q_d[i] = q_q[i];
          2'b01:   q_d[i] = 1'b0;
          2'b10:   q_d[i] = 1'b1;
          default: q_d[i] = ~q_q[i];
        endcase
      end
    end
  end

  // Reset wins over J/K and over a deasserted enable.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      q_q <= INIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign Q   = q_q;
  assign Q_b = ~q_q;

endmodule

// File: tb/tb_jk_ff.sv
// Directed bench for jk_ff: a 1-bit instance and a 4-bit instance with INIT=1010.
// Define JK_FF_CE_EN to also exercise the clock enable.
module tb_jk_ff;

  logic       clk = 1'b0;
  logic       r1  = 1'b0;
  logic       j1  = 1'b0;
  logic       k1  = 1'b0;
  logic       q1;
  logic       qb1;
  logic       r4  = 1'b0;
  logic [3:0] j4  = '0;
  logic [3:0] k4  = '0;
  logic [3:0] q4;
  logic [3:0] qb4;
  logic       ce1 = 1'b1;
  logic       ce4 = 1'b1;

  int nvec = 0;
  int nerr = 0;

  always #10 clk = ~clk;

  jk_ff #(.WIDTH(1), .INIT(1'b0)) u1 (
    .Clk (clk),
    .Rst (r1),
`ifdef JK_FF_CE_EN
    .CE  (ce1),
`endif
    .J   (j1),
    .K   (k1),
    .Q   (q1),
    .Q_b (qb1)
  );

  jk_ff #(.WIDTH(4), .INIT(4'b1010)) u4 (
    .Clk (clk),
    .Rst (r4),
`ifdef JK_FF_CE_EN
    .CE  (ce4),
`endif
    .J   (j4),
    .K   (k4),
    .Q   (q4),
    .Q_b (qb4)
  );

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv1(input logic r, input logic j, input logic k);
    @(negedge clk);
    r1 = r;
    j1 = j;
    k1 = k;
    tick();
  endtask

  task automatic chk1(input string tag, input logic exp);
    chk({tag, "_q"},  {3'b0, q1},  {3'b0, exp});
    chk({tag, "_qb"}, {3'b0, qb1}, {3'b0, ~exp});
  endtask

  initial begin
    logic [4:0] tog;
    tog = 5'b10101;

    // 4-bit: set before any reset yields a defined value
    @(negedge clk);
    j4 = 4'b1111;
    k4 = 4'b0000;
    tick();
    chk("pre_reset_set", q4, 4'b1111);
    @(negedge clk);
    r4 = 1'b1;
    j4 = 4'b1111;
    k4 = 4'b1111;
    tick();
    chk("w4_reset_q", q4, 4'b1010);
    chk("w4_reset_qb", qb4, 4'b0101);
    @(negedge clk);
    r4 = 1'b0;
    j4 = 4'b0011;
    k4 = 4'b0101;
    tick();
    chk("w4_mixed_q", q4, 4'b1011);
    chk("w4_mixed_qb", qb4, 4'b0100);
    @(negedge clk);
    j4 = 4'b0001;
    k4 = 4'b0001;
    tick();
    chk("w4_bit0_toggle", q4, 4'b1010);
    @(negedge clk);
    j4 = 4'b0000;
    k4 = 4'b0000;

    // 1-bit vectors
    drv1(1'b1, 1'b0, 1'b0);
    chk1("reset", 1'b0);
    for (int i = 0; i < 5; i++) begin
      drv1(1'b0, 1'b0, 1'b0);
      chk1("hold0", 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      drv1(1'b0, 1'b1, 1'b0);
      chk1("set", 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      drv1(1'b0, 1'b0, 1'b1);
      chk1("clr", 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      drv1(1'b0, 1'b1, 1'b1);
      chk1("toggle", tog[4-i]);
    end
    drv1(1'b1, 1'b1, 1'b1);
    chk1("reset_over_toggle", 1'b0);

    // J pulse between edges is ignored
    @(negedge clk);
    r1 = 1'b0;
    j1 = 1'b1;
    k1 = 1'b0;
    #3;
    j1 = 1'b0;
    tick();
    chk1("j_glitch", 1'b0);

    // Rst pulse between edges is ignored
    drv1(1'b0, 1'b1, 1'b0);
    chk1("set_again", 1'b1);
    @(negedge clk);
    j1 = 1'b0;
    r1 = 1'b1;
    #3;
    r1 = 1'b0;
    tick();
    chk1("rst_glitch", 1'b1);

`ifdef JK_FF_CE_EN
    drv1(1'b1, 1'b0, 1'b0);
    chk1("ce_reset", 1'b0);
    @(negedge clk);
    ce1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drv1(1'b0, 1'b1, 1'b0);
      chk1("ce_off_hold", 1'b0);
    end
    @(negedge clk);
    ce1 = 1'b1;
    tick();
    chk1("ce_on_set", 1'b1);
    @(negedge clk);
    ce1 = 1'b0;
    drv1(1'b1, 1'b1, 1'b0);
    chk1("ce_off_reset", 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
